// File: rtl/pacman_pkg.sv
// rtl/pacman_pkg.sv - shared types and VGA constants for the Pac-Man motion slice
package pacman_pkg;

   localparam int H_VISIBLE_AREA = 640;
   localparam int V_VISIBLE_AREA = 480;

   typedef enum logic [1:0] {
      DIR_RIGHT = 2'd0,
      DIR_DOWN  = 2'd1,
      DIR_LEFT  = 2'd2,
      DIR_UP    = 2'd3
   } dir_t;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_Q_TURN,
      ST_Q_FWD,
      ST_UPDATE
   } motion_state_t;

endpackage

// File: rtl/pacman_motion_btn_debounce.sv
// rtl/pacman_motion_btn_debounce.sv - button synchronizer and debouncer with rising-edge pulse
module btn_debounce
   import pacman_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 250000
) (
   input  logic i_clk,
   input  logic i_rst_n,
   input  logic i_btn,
   output logic o_rise
);

   localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

   logic          r_sync1;
   logic          r_sync2;
   logic          r_level;
   logic          r_rise;
   logic [CW-1:0] r_cnt;

   // Synchronize, then accept a new level only after it differs for DEBOUNCE_CYCLES cycles
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_sync1 <= 1'b0;
         r_sync2 <= 1'b0;
         r_level <= 1'b0;
         r_rise  <= 1'b0;
         r_cnt   <= '0;
      end else begin
         r_sync1 <= i_btn;
         r_sync2 <= r_sync1;
         r_rise  <= 1'b0;
         if (r_sync2 == r_level) begin
            r_cnt <= '0;
         end else if (r_cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
            r_level <= r_sync2;
            r_rise  <= r_sync2;
            r_cnt   <= '0;
         end else begin
            r_cnt <= r_cnt + CW'(1);
         end
      end
   end

   assign o_rise = r_rise;

endmodule

// File: rtl/pacman_motion.sv
// rtl/pacman_motion.sv - per-frame Pac-Man movement FSM with wall query handshake
module pacman_motion
   import pacman_pkg::*;
#(
   parameter int H_ADDR_WIDTH    = 10,
   parameter int V_ADDR_WIDTH    = 10,
   parameter int SPRITE_SIZE     = 16,
   parameter int STEP            = 2,
   parameter int START_X         = 312,
   parameter int START_Y         = 368,
   parameter int DEBOUNCE_CYCLES = 250000,
   parameter int ANIM_FRAMES     = 8
) (
   input  logic                    i_clk,
   input  logic                    i_rst_n,
   input  logic                    i_frame_stb,
   input  logic                    i_btn_up,
   input  logic                    i_btn_down,
   input  logic                    i_btn_left,
   input  logic                    i_btn_right,
   output logic                    o_wall_req,
   output logic [H_ADDR_WIDTH-1:0] o_wall_x,
   output logic [V_ADDR_WIDTH-1:0] o_wall_y,
   input  logic                    i_wall_ack,
   input  logic                    i_wall_hit,
   output logic [H_ADDR_WIDTH-1:0] o_pac_x,
   output logic [V_ADDR_WIDTH-1:0] o_pac_y,
   output logic [1:0]              o_pac_dir,
   output logic                    o_pac_moving,
   output logic                    o_mouth_open,
   output logic                    o_busy
);

   localparam logic [H_ADDR_WIDTH:0] X_MAX_E  = (H_ADDR_WIDTH+1)'(H_VISIBLE_AREA - SPRITE_SIZE);
   localparam logic [H_ADDR_WIDTH:0] X_STEP_E = (H_ADDR_WIDTH+1)'(STEP);
   localparam logic [V_ADDR_WIDTH:0] Y_MAX_E  = (V_ADDR_WIDTH+1)'(V_VISIBLE_AREA - SPRITE_SIZE);
   localparam logic [V_ADDR_WIDTH:0] Y_STEP_E = (V_ADDR_WIDTH+1)'(STEP);
   localparam int ACW = (ANIM_FRAMES > 1) ? $clog2(ANIM_FRAMES) : 1;

   logic w_rise_up, w_rise_down, w_rise_left, w_rise_right;

   btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_up (
      .i_clk(i_clk), .i_rst_n(i_rst_n), .i_btn(i_btn_up), .o_rise(w_rise_up));
   btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_down (
      .i_clk(i_clk), .i_rst_n(i_rst_n), .i_btn(i_btn_down), .o_rise(w_rise_down));
   btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_left (
      .i_clk(i_clk), .i_rst_n(i_rst_n), .i_btn(i_btn_left), .o_rise(w_rise_left));
   btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_right (
      .i_clk(i_clk), .i_rst_n(i_rst_n), .i_btn(i_btn_right), .o_rise(w_rise_right));

   motion_state_t           r_state;
   dir_t                    r_dir;
   dir_t                    r_qdir;
   dir_t                    r_qry_dir;
   logic                    r_qv;
   logic                    r_moving;
   logic                    r_wall_req;
   logic                    r_phase;
   logic [ACW-1:0]          r_anim_cnt;
   logic [H_ADDR_WIDTH-1:0] r_x;
   logic [H_ADDR_WIDTH-1:0] r_wall_x;
   logic [V_ADDR_WIDTH-1:0] r_y;
   logic [V_ADDR_WIDTH-1:0] r_wall_y;

   dir_t                    w_cand_dir;
   logic [H_ADDR_WIDTH:0]   w_x_inc;
   logic [V_ADDR_WIDTH:0]   w_y_inc;
   logic [H_ADDR_WIDTH-1:0] w_cand_x;
   logic [V_ADDR_WIDTH-1:0] w_cand_y;
   logic                    w_cand_ok;
   logic                    w_resolve;
   logic                    w_hit;

   assign w_cand_dir = (r_state == ST_Q_TURN) ? r_qdir : r_dir;
   assign w_x_inc    = {1'b0, r_x} + X_STEP_E;
   assign w_y_inc    = {1'b0, r_y} + Y_STEP_E;

   // Next position one step in the queried direction; horizontal wraps, vertical edges block
   always_comb begin
      w_cand_x  = r_x;
      w_cand_y  = r_y;
      w_cand_ok = 1'b1;
      case (w_cand_dir)
         DIR_RIGHT: w_cand_x = (w_x_inc > X_MAX_E) ? '0 : w_x_inc[H_ADDR_WIDTH-1:0];
         DIR_LEFT:  w_cand_x = ({1'b0, r_x} < X_STEP_E) ? X_MAX_E[H_ADDR_WIDTH-1:0]
                                                       : r_x - X_STEP_E[H_ADDR_WIDTH-1:0];
         DIR_DOWN: begin
            w_cand_y  = w_y_inc[V_ADDR_WIDTH-1:0];
            w_cand_ok = (w_y_inc <= Y_MAX_E);
         end
         DIR_UP: begin
            w_cand_y  = r_y - Y_STEP_E[V_ADDR_WIDTH-1:0];
            w_cand_ok = ({1'b0, r_y} >= Y_STEP_E);
         end
         default: w_cand_ok = 1'b1;
      endcase
   end

   // An off-screen vertical candidate resolves at once as a hit without touching the maze
   assign w_resolve = r_wall_req ? i_wall_ack : ~w_cand_ok;
   assign w_hit     = r_wall_req ? i_wall_hit : 1'b1;

   // Motion FSM, wall handshake, position/animation commit and turn queue
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state    <= ST_IDLE;
         r_dir      <= DIR_LEFT;
         r_qdir     <= DIR_RIGHT;
         r_qry_dir  <= DIR_LEFT;
         r_qv       <= 1'b0;
         r_moving   <= 1'b0;
         r_wall_req <= 1'b0;
         r_wall_x   <= '0;
         r_wall_y   <= '0;
         r_x        <= H_ADDR_WIDTH'(START_X);
         r_y        <= V_ADDR_WIDTH'(START_Y);
         r_phase    <= 1'b1;
         r_anim_cnt <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (i_frame_stb) begin
                  if (r_qv && (r_qdir != r_dir)) begin
                     r_state <= ST_Q_TURN;
                  end else if (r_qv) begin
                     r_qv    <= 1'b0;
                     r_state <= ST_Q_FWD;
                  end else if (r_moving) begin
                     r_state <= ST_Q_FWD;
                  end
               end
            end
            ST_Q_TURN, ST_Q_FWD: begin
               if (!r_wall_req && w_cand_ok) begin
                  r_wall_req <= 1'b1;
                  r_wall_x   <= w_cand_x;
                  r_wall_y   <= w_cand_y;
                  r_qry_dir  <= w_cand_dir;
               end else if (w_resolve) begin
                  r_wall_req <= 1'b0;
                  if (r_state == ST_Q_TURN) begin
                     if (w_hit) begin
                        r_state <= ST_Q_FWD;
                     end else begin
                        r_dir   <= r_qry_dir;
                        r_qv    <= 1'b0;
                        r_state <= ST_UPDATE;
                     end
                  end else if (w_hit) begin
                     r_moving <= 1'b0;
                     r_state  <= ST_IDLE;
                  end else begin
                     r_state <= ST_UPDATE;
                  end
               end
            end
            ST_UPDATE: begin
               r_x      <= r_wall_x;
               r_y      <= r_wall_y;
               r_moving <= 1'b1;
               if (r_anim_cnt == '0) begin
                  r_phase <= ~r_phase;
               end
               r_anim_cnt <= (r_anim_cnt == ACW'(ANIM_FRAMES - 1)) ? '0 : r_anim_cnt + ACW'(1);
               r_state    <= ST_IDLE;
            end
            default: r_state <= ST_IDLE;
         endcase

         if (w_rise_up) begin
            r_qdir <= DIR_UP;
            r_qv   <= 1'b1;
         end else if (w_rise_down) begin
            r_qdir <= DIR_DOWN;
            r_qv   <= 1'b1;
         end else if (w_rise_left) begin
            r_qdir <= DIR_LEFT;
            r_qv   <= 1'b1;
         end else if (w_rise_right) begin
            r_qdir <= DIR_RIGHT;
            r_qv   <= 1'b1;
         end
      end
   end

   assign o_wall_req   = r_wall_req;
   assign o_wall_x     = r_wall_x;
   assign o_wall_y     = r_wall_y;
   assign o_pac_x      = r_x;
   assign o_pac_y      = r_y;
   assign o_pac_dir    = r_dir;
   assign o_pac_moving = r_moving;
   assign o_mouth_open = r_phase | ~r_moving;
   assign o_busy       = (r_state != ST_IDLE);

endmodule

// File: tb/tb_pacman_motion.sv
// tb/tb_pacman_motion.sv - randomized self-checking bench for pacman_motion
module tb_pacman_motion;

   localparam int XM   = 624;
   localparam int YM   = 464;
   localparam int STP  = 2;
   localparam int ANIM = 2;

   logic       clk = 1'b0;
   logic       i_rst_n = 1'b0;
   logic       i_frame_stb = 1'b0;
   logic       i_btn_up = 1'b0, i_btn_down = 1'b0, i_btn_left = 1'b0, i_btn_right = 1'b0;
   logic       i_wall_ack = 1'b0, i_wall_hit = 1'b0;
   logic       o_wall_req;
   logic [9:0] o_wall_x, o_pac_x;
   logic [9:0] o_wall_y, o_pac_y;
   logic [1:0] o_pac_dir;
   logic       o_pac_moving, o_mouth_open, o_busy;

   pacman_motion #(.DEBOUNCE_CYCLES(4), .ANIM_FRAMES(ANIM)) dut (
      .i_clk(clk), .i_rst_n(i_rst_n), .i_frame_stb(i_frame_stb),
      .i_btn_up(i_btn_up), .i_btn_down(i_btn_down),
      .i_btn_left(i_btn_left), .i_btn_right(i_btn_right),
      .o_wall_req(o_wall_req), .o_wall_x(o_wall_x), .o_wall_y(o_wall_y),
      .i_wall_ack(i_wall_ack), .i_wall_hit(i_wall_hit),
      .o_pac_x(o_pac_x), .o_pac_y(o_pac_y), .o_pac_dir(o_pac_dir),
      .o_pac_moving(o_pac_moving), .o_mouth_open(o_mouth_open), .o_busy(o_busy));

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // reference model state
   int m_x, m_y, m_dir, m_qdir, m_n;
   bit m_qv, m_moving;
   bit m_valid   = 1'b0;
   bit exp_armed = 1'b0;
   int exp_x, exp_y, last_wx, last_wy, frame_q;

   task automatic chk(input string name, input logic [31:0] act, input int exp);
      checks++;
      if (act !== 32'(exp)) begin
         errors++;
         $display("FAIL %s actual %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic int exp_mouth();
      if (!m_moving) return 1;
      return ((((m_n + ANIM - 1) / ANIM) % 2) == 0) ? 1 : 0;
   endfunction

   function automatic void cand(input int d, output bit ok, output int cx, output int cy);
      cx = m_x;
      cy = m_y;
      ok = 1'b1;
      case (d)
         0: cx = (m_x + STP > XM) ? 0 : m_x + STP;
         1: begin cy = m_y + STP; ok = (cy <= YM); end
         2: cx = (m_x < STP) ? XM : m_x - STP;
         default: begin cy = m_y - STP; ok = (cy >= 0); end
      endcase
   endfunction

   // every cycle: request coordinates against the expected query, idle outputs against the model
   always @(negedge clk) begin
      if (i_rst_n) begin
         if (!exp_armed) begin
            chk("no_unexpected_req", o_wall_req, 0);
         end else if (o_wall_req) begin
            chk("wall_x", o_wall_x, exp_x);
            chk("wall_y", o_wall_y, exp_y);
         end
         if (m_valid && !o_busy) begin
            chk("pac_x", o_pac_x, m_x);
            chk("pac_y", o_pac_y, m_y);
            chk("pac_dir", o_pac_dir, m_dir);
            chk("pac_moving", o_pac_moving, m_moving);
            chk("mouth_open", o_mouth_open, exp_mouth());
         end
      end
   end

   task automatic apply_reset();
      i_rst_n   = 1'b0;
      m_valid   = 1'b0;
      exp_armed = 1'b0;
      #1;
      chk("rst_wall_req", o_wall_req, 0);
      chk("rst_pac_x", o_pac_x, 312);
      chk("rst_pac_y", o_pac_y, 368);
      chk("rst_pac_dir", o_pac_dir, 2);
      chk("rst_moving", o_pac_moving, 0);
      chk("rst_mouth", o_mouth_open, 1);
      chk("rst_busy", o_busy, 0);
      chk("rst_wall_x", o_wall_x, 0);
      repeat (2) tick();
      i_rst_n = 1'b1;
      tick();
      m_x = 312; m_y = 368; m_dir = 2; m_qdir = 0; m_n = 0;
      m_qv = 1'b0; m_moving = 1'b0;
      m_valid = 1'b1;
   endtask

   task automatic set_btns(input logic [3:0] mask);
      i_btn_up    = mask[3];
      i_btn_down  = mask[2];
      i_btn_left  = mask[1];
      i_btn_right = mask[0];
   endtask

   task automatic press(input logic [3:0] mask);
      set_btns(mask);
      repeat (10) tick();
      set_btns(4'b0000);
      repeat (12) tick();
      if (mask != 4'b0000) begin
         m_qv   = 1'b1;
         m_qdir = mask[3] ? 3 : mask[2] ? 1 : mask[1] ? 2 : 0;
      end
   endtask

   task automatic glitch(input logic [3:0] mask);
      set_btns(mask);
      repeat (2) tick();
      set_btns(4'b0000);
      repeat (12) tick();
   endtask

   task automatic query(input int d, input int hs, input int ls, input bit extra,
                        output bit pass, output int cx, output int cy);
      bit ok;
      bit seen;
      bit hit;
      int lat;
      cand(d, ok, cx, cy);
      pass = 1'b0;
      if (!ok) return;
      exp_x = cx;
      exp_y = cy;
      exp_armed = 1'b1;
      seen = 1'b0;
      for (int i = 0; i < 10 && !seen; i++) begin
         tick();
         seen = o_wall_req;
      end
      chk("req_seen", seen, 1);
      if (!seen) begin
         exp_armed = 1'b0;
         return;
      end
      frame_q++;
      last_wx = int'(o_wall_x);
      last_wy = int'(o_wall_y);
      lat = (ls < 0) ? int'($urandom_range(0, 4)) : ls;
      for (int i = 0; i < lat; i++) begin
         i_frame_stb = extra && (i == 0);
         tick();
      end
      i_frame_stb = 1'b0;
      hit = (hs < 0) ? ($urandom_range(0, 3) == 0) : hs[0];
      i_wall_ack = 1'b1;
      i_wall_hit = hit;
      tick();
      i_wall_ack = 1'b0;
      i_wall_hit = 1'($urandom_range(0, 1));
      exp_armed  = 1'b0;
      pass = !hit;
   endtask

   task automatic do_frame(input int ht, input int hf, input int ls, input bit extra);
      bit pass, fwd, idle;
      int cx, cy;
      m_valid = 1'b0;
      frame_q = 0;
      i_frame_stb = 1'b1;
      tick();
      i_frame_stb = 1'b0;
      fwd = 1'b0;
      if (m_qv && m_qdir != m_dir) begin
         query(m_qdir, ht, ls, extra, pass, cx, cy);
         if (pass) begin
            m_dir = m_qdir; m_qv = 1'b0;
            m_x = cx; m_y = cy; m_moving = 1'b1; m_n++;
         end else begin
            fwd = 1'b1;
         end
      end else if (m_qv) begin
         m_qv = 1'b0;
         fwd  = 1'b1;
      end else begin
         fwd = m_moving;
      end
      if (fwd) begin
         query(m_dir, hf, ls, extra, pass, cx, cy);
         if (pass) begin
            m_x = cx; m_y = cy; m_moving = 1'b1; m_n++;
         end else begin
            m_moving = 1'b0;
         end
      end
      idle = 1'b0;
      for (int i = 0; i < 20 && !idle; i++) begin
         if (!o_busy) idle = 1'b1;
         else tick();
      end
      chk("frame_done", idle, 1);
      m_valid = 1'b1;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog actual timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int mseq[5];
      int mexp[5];
      int cx, cy;
      bit ok, seen;
      mexp[0] = 1; mexp[1] = 0; mexp[2] = 0; mexp[3] = 1; mexp[4] = 1;

      tick();
      apply_reset();

      // left press then four unblocked frames: first move to 310, mouth pattern pinned
      mseq[0] = int'(o_mouth_open);
      press(4'b0010);
      do_frame(0, 0, 3, 1'b0);
      chk("t2_wall_x", last_wx, 310);
      chk("t2_wall_y", last_wy, 368);
      chk("t2_pac_x", o_pac_x, 310);
      chk("t2_moving", o_pac_moving, 1);
      chk("t2_busy", o_busy, 0);
      mseq[1] = int'(o_mouth_open);
      do_frame(0, 0, 20, 1'b1);
      chk("t6_one_step", o_pac_x, 308);
      mseq[2] = int'(o_mouth_open);
      do_frame(0, 0, -1, 1'b0);
      mseq[3] = int'(o_mouth_open);
      do_frame(0, 0, -1, 1'b0);
      mseq[4] = int'(o_mouth_open);
      for (int i = 0; i < 5; i++) chk($sformatf("mouth_seq%0d", i), mseq[i], mexp[i]);

      // blocked turn keeps direction and queue, next frame turns up
      press(4'b1000);
      do_frame(1, 0, -1, 1'b0);
      chk("t3_dir_kept", o_pac_dir, 2);
      chk("t3_pac_x", o_pac_x, 302);
      do_frame(0, 0, -1, 1'b0);
      chk("t3_dir_up", o_pac_dir, 3);
      chk("t3_pac_y", o_pac_y, 366);

      // reset while a forward query is outstanding
      m_valid = 1'b0;
      i_frame_stb = 1'b1;
      tick();
      i_frame_stb = 1'b0;
      cand(m_dir, ok, cx, cy);
      exp_x = cx; exp_y = cy; exp_armed = 1'b1;
      seen = 1'b0;
      for (int i = 0; i < 10 && !seen; i++) begin
         tick();
         seen = o_wall_req;
      end
      chk("t1_req_up", seen, 1);
      apply_reset();

      // glitch ignored, simultaneous up+right resolves to up
      glitch(4'b0001);
      press(4'b1001);
      do_frame(0, 0, -1, 1'b0);
      chk("t5_dir_up", o_pac_dir, 3);
      chk("t5_pac_y", o_pac_y, 366);

      // randomized traffic
      for (int r = 0; r < 80; r++) begin
         int act;
         act = int'($urandom_range(0, 5));
         if (act == 0) glitch(4'(1 << $urandom_range(0, 3)));
         else if (act <= 2) press(4'($urandom_range(1, 15)));
         if ($urandom_range(0, 4) == 0) begin
            i_wall_ack = 1'b1;
            tick();
            i_wall_ack = 1'b0;
         end
         do_frame(-1, -1, -1, $urandom_range(0, 2) == 0);
      end

      // horizontal wrap and top edge block
      apply_reset();
      press(4'b0010);
      for (int i = 0; i < 200 && m_x != 0; i++) do_frame(0, 0, 0, 1'b0);
      do_frame(0, 0, 0, 1'b0);
      chk("t4_wrap_wall_x", last_wx, 624);
      chk("t4_wrap_pac_x", o_pac_x, 624);
      press(4'b1000);
      for (int i = 0; i < 250 && m_y != 0; i++) do_frame(0, 0, 0, 1'b0);
      chk("t4_top_y", o_pac_y, 0);
      do_frame(0, 0, 0, 1'b0);
      chk("t4_no_query", frame_q, 0);
      chk("t4_stopped", o_pac_moving, 0);
      repeat (3) tick();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
